// File: rtl/wb_interrupt_ctrl.sv
// Wishbone interrupt controller: edge-captured pending bits, enable mask, lowest-index dispatch to the core.
// Bus ack/err one cycle after request, no wait states; trigger follows a visible pending bit by one cycle.
module wb_interrupt_ctrl #(
    parameter int XLEN         = 32,
    parameter int INT_VECT_LEN = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [XLEN-1:0]         slave_dat_i,
    output logic [XLEN-1:0]         slave_dat_o,
    input  logic [XLEN-3:0]         adr_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [3:0]              sel_i,
    output logic                    ack_o,
    output logic                    err_o,
    input  logic [INT_VECT_LEN-1:0] irq_i,
    output logic                    interrupt_trigger_o,
    output logic [XLEN-1:0]         interrupt_vector_offset_o,
    input  logic                    interrupt_routine_complete_i
);

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_SWTRIG  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        TRIGGER,
        SERVICE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [INT_VECT_LEN-1:0] pending;
    logic [INT_VECT_LEN-1:0] enable;
    logic [INT_VECT_LEN-1:0] irq_q;
    logic [INT_VECT_LEN-1:0] irq_rise;
    logic [INT_VECT_LEN-1:0] lane_mask;
    logic [INT_VECT_LEN-1:0] wdat;
    logic [INT_VECT_LEN-1:0] qualified;
    logic [INT_VECT_LEN-1:0] dispatch_oh;
    logic [INT_VECT_LEN-1:0] set_bits;
    logic [INT_VECT_LEN-1:0] clr_bits;
    logic [7:0]              active_idx;
    logic [7:0]              next_idx;
    logic [1:0]              reg_sel;
    logic                    req;
    logic                    wr;
    logic                    status_wr;
    logic                    in_service;
    logic [XLEN-1:0]         rdata;
    logic                    unused_bits;

    assign reg_sel   = adr_i[1:0];
    // Blocking on err_o as well as ack_o keeps every response a single-cycle pulse.
    assign req       = cyc_i & stb_i & ~ack_o & ~err_o;
    assign wr        = req & we_i;
    assign status_wr = wr & (reg_sel == REG_STATUS);
    assign in_service = (state != IDLE);
    assign qualified = pending & enable;
    assign irq_rise  = irq_i & ~irq_q;
    assign unused_bits = ^{adr_i[XLEN-3:2], slave_dat_i};

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < INT_VECT_LEN; i++) begin
            lane_mask[i] = sel_i[2'(i >> 3)];
        end
    end

    assign wdat = slave_dat_i[INT_VECT_LEN-1:0] & lane_mask;

    // Set sources are OR-ed in after clears so a coincident set always wins.
    assign set_bits = irq_rise | ((wr && reg_sel == REG_SWTRIG) ? wdat : '0);
    assign clr_bits = ((wr && reg_sel == REG_PENDING) ? wdat : '0) | dispatch_oh;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        next_idx    = active_idx;
        dispatch_oh = '0;
        case (state)
            IDLE: begin
                if (|qualified) begin
                    for (int i = INT_VECT_LEN - 1; i >= 0; i--) begin
                        if (qualified[i]) begin
                            next_idx = 8'(i);
                        end
                    end
                    dispatch_oh = INT_VECT_LEN'(1) << next_idx;
                    state_nxt   = TRIGGER;
                end
            end
            TRIGGER: state_nxt = SERVICE;
            SERVICE: begin
                if (interrupt_routine_complete_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_PENDING: rdata = XLEN'(pending);
            REG_ENABLE:  rdata = XLEN'(enable);
            REG_STATUS: begin
                rdata[XLEN-1] = in_service;
                rdata[7:0]    = active_idx;
            end
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending     <= '0;
            enable      <= '0;
            irq_q       <= '0;
            active_idx  <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            slave_dat_o <= '0;
        end else begin
            irq_q      <= irq_i;
            pending    <= (pending & ~clr_bits) | set_bits;
            active_idx <= next_idx;
            if (wr && reg_sel == REG_ENABLE) begin
                enable <= (enable & ~lane_mask) | wdat;
            end
            ack_o       <= req & ~status_wr;
            err_o       <= status_wr;
            slave_dat_o <= req ? rdata : '0;
        end
    end

    assign interrupt_trigger_o       = (state == TRIGGER);
    assign interrupt_vector_offset_o = XLEN'({active_idx, 2'b00});

endmodule

// File: tb/tb_wb_interrupt_ctrl.sv
// Directed bench for wb_interrupt_ctrl: register table plus dispatch, edge, W1C and reset sequences.
module tb_wb_interrupt_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] slave_dat_i;
    logic [31:0] slave_dat_o;
    logic [29:0] adr_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic        err_o;
    logic [7:0]  irq_i;
    logic        interrupt_trigger_o;
    logic [31:0] interrupt_vector_offset_o;
    logic        interrupt_routine_complete_i;

    always #5 clk_i = ~clk_i;

    wb_interrupt_ctrl #(.XLEN(32), .INT_VECT_LEN(8)) dut (
        .clk_i                        (clk_i),
        .reset_i                      (reset_i),
        .slave_dat_i                  (slave_dat_i),
        .slave_dat_o                  (slave_dat_o),
        .adr_i                        (adr_i),
        .cyc_i                        (cyc_i),
        .stb_i                        (stb_i),
        .we_i                         (we_i),
        .sel_i                        (sel_i),
        .ack_o                        (ack_o),
        .err_o                        (err_o),
        .irq_i                        (irq_i),
        .interrupt_trigger_o          (interrupt_trigger_o),
        .interrupt_vector_offset_o    (interrupt_vector_offset_o),
        .interrupt_routine_complete_i (interrupt_routine_complete_i)
    );

    int          tests = 0;
    int          fails = 0;
    int          trig_cnt = 0;
    int          trig_dbl = 0;
    logic        trig_prev = 1'b0;
    logic [31:0] last_off = '0;

    // Trigger monitor: counts pulses, records offset, flags pulses longer than one cycle.
    always @(negedge clk_i) begin
        if (interrupt_trigger_o === 1'b1) begin
            trig_cnt = trig_cnt + 1;
            last_off = interrupt_vector_offset_o;
            if (trig_prev) trig_dbl = trig_dbl + 1;
        end
        trig_prev = (interrupt_trigger_o === 1'b1);
    end

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic ak, output logic er);
        logic [29:0] junk;
        junk        = 30'($urandom);
        junk[1:0]   = a;
        adr_i       = junk;
        cyc_i       = 1'b1;
        stb_i       = 1'b1;
        we_i        = w;
        sel_i       = s;
        slave_dat_i = d;
        tick();
        ak    = ack_o;
        er    = err_o;
        rd    = slave_dat_o;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        tick();
        chk("resp_single_cycle", {30'b0, ack_o, err_o}, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        logic ak, er;
        wb(1'b1, a, s, d, rd, ak, er);
        chk("wr_ack", {31'b0, ak}, 32'h1);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic ak, er;
        wb(1'b0, a, 4'hF, 32'h0, rd, ak, er);
        chk(nm, rd, exp);
    endtask

    task automatic complete_pulse();
        interrupt_routine_complete_i = 1'b1;
        tick();
        interrupt_routine_complete_i = 1'b0;
    endtask

    task automatic wait_trig(input string nm, input int target);
        for (int i = 0; i < 30 && trig_cnt < target; i++) tick();
        chk(nm, 32'(trig_cnt), 32'(target));
    endtask

    initial begin
        int base;
        logic [31:0] rd;
        logic ak, er;

        reset_i = 1'b1;
        slave_dat_i = '0;
        adr_i = '0;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i = 1'b0;
        sel_i = '0;
        irq_i = '0;
        interrupt_routine_complete_i = 1'b0;

        vecs[0] = '{1'b1, 2'd1, 4'b0001, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 2'd1, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_00FF};
        vecs[2] = '{1'b1, 2'd1, 4'b0010, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 2'd1, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_00FF};
        vecs[4] = '{1'b1, 2'd1, 4'b0000, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 2'd1, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_00FF};
        vecs[6] = '{1'b0, 2'd0, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 2'd3, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8] = '{1'b1, 2'd2, 4'b1111, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 2'd2, 4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};

        repeat (2) tick();
        chk("rst_ack", {31'b0, ack_o}, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_trig", {31'b0, interrupt_trigger_o}, 32'h0);
        chk("rst_offset", interrupt_vector_offset_o, 32'h0);
        chk("rst_dat", slave_dat_o, 32'h0);
        reset_i = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            wb(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rd, ak, er);
            chk($sformatf("vec%0d_ack", i), {31'b0, ak}, {31'b0, vecs[i].exp_ack});
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            if (vecs[i].chk_dat) chk($sformatf("vec%0d_dat", i), rd, vecs[i].exp_dat);
        end

        // Hold the core in service on source 7 so sources 5 and 2 accumulate together.
        base = trig_cnt;
        wr(2'd3, 4'b0001, 32'h80);
        wait_trig("swtrig7_dispatch", base + 1);
        chk("swtrig7_offset", last_off, 32'h1C);
        irq_i = 8'h20; tick(); irq_i = 8'h00; tick();
        irq_i = 8'h04; tick(); irq_i = 8'h00; tick();
        rd_chk("accum_pending", 2'd0, 32'h24);
        chk("no_nesting", 32'(trig_cnt), 32'(base + 1));
        complete_pulse();
        wait_trig("irq2_dispatch", base + 2);
        chk("irq2_offset", last_off, 32'h08);
        rd_chk("status_irq2", 2'd2, 32'h8000_0002);
        chk("offset_stable", interrupt_vector_offset_o, 32'h08);
        rd_chk("pending_after2", 2'd0, 32'h20);
        complete_pulse();
        wait_trig("irq5_dispatch", base + 3);
        chk("irq5_offset", last_off, 32'h14);
        complete_pulse();
        repeat (3) tick();
        rd_chk("status_idle", 2'd2, 32'h0000_0005);

        // Level held high sets pending once only.
        base = trig_cnt;
        irq_i = 8'h08;
        repeat (5) tick();
        rd_chk("held_pending", 2'd0, 32'h0);
        repeat (3) tick();
        irq_i = 8'h00;
        chk("held_dispatch", 32'(trig_cnt), 32'(base + 1));
        chk("held_offset", last_off, 32'h0C);
        complete_pulse();
        repeat (5) tick();
        chk("held_one_dispatch", 32'(trig_cnt), 32'(base + 1));

        // Masked source stays pending; W1C coinciding with a new edge loses to the set.
        base = trig_cnt;
        wr(2'd1, 4'b0001, 32'hEF);
        irq_i = 8'h10; tick(); irq_i = 8'h00; tick();
        rd_chk("masked_pending", 2'd0, 32'h10);
        chk("masked_no_dispatch", 32'(trig_cnt), 32'(base));
        adr_i = 30'h0; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
        sel_i = 4'b0001; slave_dat_i = 32'h10; irq_i = 8'h10;
        tick();
        chk("coincide_ack", {31'b0, ack_o}, 32'h1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; irq_i = 8'h00;
        tick();
        rd_chk("set_beats_clear", 2'd0, 32'h10);
        wr(2'd1, 4'b0001, 32'hFF);
        wait_trig("reenable_dispatch", base + 1);
        chk("reenable_offset", last_off, 32'h10);
        complete_pulse();
        wr(2'd1, 4'b0001, 32'h00);
        wr(2'd3, 4'b0001, 32'h41);
        rd_chk("swtrig_pending", 2'd0, 32'h41);
        wr(2'd0, 4'b0001, 32'h01);
        rd_chk("w1c_pending", 2'd0, 32'h40);
        wr(2'd0, 4'b0000, 32'h40);
        rd_chk("w1c_no_lane", 2'd0, 32'h40);

        // Reset in SERVICE with work pending and a bus request in the reset cycle.
        wr(2'd0, 4'b0001, 32'h40);
        base = trig_cnt;
        wr(2'd1, 4'b0001, 32'h80);
        wr(2'd3, 4'b0001, 32'h80);
        wait_trig("pre_reset_dispatch", base + 1);
        wr(2'd3, 4'b0001, 32'h03);
        rd_chk("pre_reset_pending", 2'd0, 32'h03);
        rd_chk("pre_reset_status", 2'd2, 32'h8000_0007);
        reset_i = 1'b1; adr_i = 30'h1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        tick();
        reset_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        chk("reset_no_ack", {31'b0, ack_o}, 32'h0);
        chk("reset_err", {31'b0, err_o}, 32'h0);
        chk("reset_trig", {31'b0, interrupt_trigger_o}, 32'h0);
        chk("reset_offset", interrupt_vector_offset_o, 32'h0);
        chk("reset_dat", slave_dat_o, 32'h0);
        tick();
        chk("reset_no_late_ack", {31'b0, ack_o}, 32'h0);
        rd_chk("reset_pending", 2'd0, 32'h0);
        rd_chk("reset_enable", 2'd1, 32'h0);
        rd_chk("reset_status", 2'd2, 32'h0);
        base = trig_cnt;
        repeat (10) tick();
        chk("reset_no_trigger", 32'(trig_cnt), 32'(base));
        wr(2'd1, 4'b0001, 32'h01);
        wr(2'd3, 4'b0001, 32'h01);
        wait_trig("post_reset_dispatch", base + 1);
        chk("post_reset_offset", last_off, 32'h0);
        complete_pulse();
        repeat (3) tick();

        chk("trigger_one_cycle", 32'(trig_dbl), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
